ernic_crc32_stream: RTL

ERNIC_CRC32_STREAM -- requirements
Module: ernic_crc32_stream

---
 rtl/ernic_crc32_stream.sv | 110 +++++++++++
 1 files changed

// File: rtl/ernic_crc32_stream.sv
// rtl/ernic_crc32_stream.sv - streaming CRC-32 over byte-masked beats, one frame result per last beat
// Optional macro ERNIC_CRC_FINAL_INV_EN: presents the bitwise inverse of the final CRC on crc_out.
module ernic_crc32_stream #(
    parameter int          DATA_W    = 64,
    parameter logic [31:0] INIT_SEED = 32'h0000_0000,
    parameter logic [31:0] POLY      = 32'h04C1_1DB7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_last,
    output logic                crc_valid,
    input  logic                crc_ready,
    output logic [31:0]         crc_out,
    output logic [15:0]         crc_len
);

    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_out_q, crc_out_d;
    logic [15:0] crc_len_q, crc_len_d;

    logic [31:0] fold_crc;
    logic [31:0] final_crc;
    logic [16:0] fold_sum;
    logic [15:0] new_len;
    logic        accept;

    assign crc_valid = (state_q == DONE);
    assign s_ready   = !crc_valid || crc_ready;
    assign accept    = s_valid && s_ready;
    assign crc_out   = crc_out_q;
    assign crc_len   = crc_len_q;

    // Whole beat folded combinationally, LSB-first within each kept byte.
    always_comb begin
        fold_crc = crc_q;
        fold_sum = {1'b0, cnt_q};
        for (int k = 0; k < NB; k++) begin
            if (s_keep[k]) begin
                for (int b = 0; b < 8; b++) begin
                    fold_crc = {fold_crc[30:0], 1'b0}
                             ^ ((fold_crc[31] ^ s_data[8*k+b]) ? POLY : 32'h0000_0000);
                end
                fold_sum = fold_sum + 17'd1;
            end
        end
    end

    // cnt_q never exceeds 16'hFFFF, so one carry bit is enough to detect saturation.
    assign new_len = fold_sum[16] ? 16'hFFFF : fold_sum[15:0];

`ifdef ERNIC_CRC_FINAL_INV_EN
    assign final_crc = ~fold_crc;
`else
    assign final_crc = fold_crc;
`endif

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        crc_out_d = crc_out_q;
        crc_len_d = crc_len_q;
        if (accept) begin
            if (s_last) begin
                state_d   = DONE;
                crc_d     = INIT_SEED;
                cnt_d     = 16'd0;
                crc_out_d = final_crc;
                crc_len_d = new_len;
            end else begin
                state_d   = BUSY;
                crc_d     = fold_crc;
                cnt_d     = new_len;
            end
        end else if (state_q == DONE && crc_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT_SEED;
            cnt_q     <= 16'd0;
            crc_out_q <= 32'd0;
            crc_len_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            crc_out_q <= crc_out_d;
            crc_len_q <= crc_len_d;
        end
    end

endmodule
